gshare_predictor: RTL and testbench

//   Gshare branch predictor in the IF stage, directly upstream of the next-PC 4x1 mux. Each cycle
//   it looks up the fetch PC in a PHT of 2-bit counters (indexed PC XOR global history) and a

---
 rtl/gshare_predictor.sv | 82 ++++++++
 tb/tb_gshare_predictor.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/gshare_predictor.sv
// gshare_predictor: gshare direction predictor plus tagged BTB feeding the IF next-PC mux.
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   fetch_pc                     PC in IF, looked up combinationally
//   pred_taken/pred_target       predicted direction (BTB hit and PHT taken) and next fetch address
//   pred_index                   PHT index of this lookup, carried down the pipe to EX
//   pc_sel                       00 pc+4, 01 pred_target, 10 EX redirect
//   update_*                     training from EX for each resolved control-flow instruction
module gshare_predictor #(
  parameter int ADDR_WIDTH = 32,
  parameter int GHR_WIDTH  = 5
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [ADDR_WIDTH-1:0] fetch_pc,
  output logic                  pred_taken,
  output logic [ADDR_WIDTH-1:0] pred_target,
  output logic [GHR_WIDTH-1:0]  pred_index,
  output logic [1:0]            pc_sel,
  input  logic                  update_valid,
  input  logic [ADDR_WIDTH-1:0] update_pc,
  input  logic [GHR_WIDTH-1:0]  update_index,
  input  logic                  update_taken,
  input  logic [ADDR_WIDTH-1:0] update_target,
  input  logic                  update_mispredict
);
  localparam int N  = 1 << GHR_WIDTH;
  localparam int TW = ADDR_WIDTH - GHR_WIDTH - 2;

  logic [1:0]            r_pht    [N];
  logic [N-1:0]          r_valid;
  logic [TW-1:0]         r_tag    [N];
  logic [ADDR_WIDTH-1:0] r_target [N];
  logic [GHR_WIDTH-1:0]  r_ghr;

  logic [GHR_WIDTH-1:0]  w_fidx;
  logic [GHR_WIDTH-1:0]  w_uidx;
  logic [TW-1:0]         w_ftag;
  logic                  w_hit;
  logic [1:0]            w_cnt;
  logic [1:0]            w_cnt_next;

  assign w_fidx = fetch_pc[GHR_WIDTH+1:2];
  assign w_ftag = fetch_pc[ADDR_WIDTH-1:GHR_WIDTH+2];
  assign w_uidx = update_pc[GHR_WIDTH+1:2];
  assign w_hit  = r_valid[w_fidx] && (r_tag[w_fidx] == w_ftag);
  assign w_cnt  = r_pht[update_index];

  // saturating 2-bit counter step
  assign w_cnt_next = update_taken ? ((&w_cnt) ? 2'b11 : w_cnt + 2'b01)
                                   : ((|w_cnt) ? w_cnt - 2'b01 : 2'b00);

  // reset_n gating keeps the outputs quiet while the arrays are held in reset
  always_comb begin
    pred_index  = w_fidx ^ r_ghr;
    pred_taken  = reset_n && w_hit && r_pht[pred_index][1];
    pred_target = pred_taken ? r_target[w_fidx] : fetch_pc + ADDR_WIDTH'(4);
    pc_sel      = !reset_n ? 2'b00 :
                  (update_valid && update_mispredict) ? 2'b10 :
                  pred_taken ? 2'b01 : 2'b00;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N; i++) r_pht[i] <= 2'b01;
      r_valid <= '0;
      r_ghr   <= '0;
    end else if (update_valid) begin
      r_pht[update_index] <= w_cnt_next;
      if (update_taken) r_valid[w_uidx] <= 1'b1;
      r_ghr <= {r_ghr[GHR_WIDTH-2:0], update_taken};
    end
  end

  // tag/target payload is qualified by r_valid, so it needs no reset
  always_ff @(posedge clk) begin
    if (update_valid && update_taken) begin
      r_tag[w_uidx]    <= update_pc[ADDR_WIDTH-1:GHR_WIDTH+2];
      r_target[w_uidx] <= update_target;
    end
  end
endmodule

// File: tb/tb_gshare_predictor.sv
// tb_gshare_predictor: checks gshare_predictor against an array-based reference model.
module tb_gshare_predictor;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] fetch_pc = '0;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic [4:0]  pred_index;
  logic [1:0]  pc_sel;
  logic        update_valid = 1'b0;
  logic [31:0] update_pc = '0;
  logic [4:0]  update_index = '0;
  logic        update_taken = 1'b0;
  logic [31:0] update_target = '0;
  logic        update_mispredict = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  int          m_pht [32];
  bit          m_valid [32];
  int unsigned m_tag [32];
  logic [31:0] m_tgt [32];
  int          m_ghr;

  gshare_predictor dut (
    .clk(clk), .reset_n(reset_n), .fetch_pc(fetch_pc),
    .pred_taken(pred_taken), .pred_target(pred_target), .pred_index(pred_index), .pc_sel(pc_sel),
    .update_valid(update_valid), .update_pc(update_pc), .update_index(update_index),
    .update_taken(update_taken), .update_target(update_target), .update_mispredict(update_mispredict)
  );

  always #5 clk = ~clk;

  task automatic model_reset;
    for (int i = 0; i < 32; i++) begin
      m_pht[i] = 1;
      m_valid[i] = 0;
    end
    m_ghr = 0;
  endtask

  function automatic void exp_out(input logic [31:0] pc, output logic [4:0] ix, output logic tk,
                                  output logic [31:0] tg);
    int i;
    i = int'((pc / 4) % 32);
    ix = 5'(i ^ m_ghr);
    tk = m_valid[i] && (m_tag[i] == pc / 128) && (m_pht[ix] >= 2);
    tg = tk ? m_tgt[i] : pc + 32'd4;
  endfunction

  task automatic tick;
    int i;
    @(posedge clk);
    if (update_valid) begin
      i = update_index;
      m_pht[i] = update_taken ? (m_pht[i] == 3 ? 3 : m_pht[i] + 1) : (m_pht[i] == 0 ? 0 : m_pht[i] - 1);
      if (update_taken) begin
        m_valid[(update_pc / 4) % 32] = 1;
        m_tag[(update_pc / 4) % 32]   = update_pc / 128;
        m_tgt[(update_pc / 4) % 32]   = update_target;
      end
      m_ghr = (m_ghr * 2 + int'(update_taken)) % 32;
    end
    #1;
  endtask

  task automatic upd(input logic [31:0] pc, input int ix, input logic t, input logic [31:0] tgt);
    update_valid = 1; update_pc = pc; update_index = 5'(ix);
    update_taken = t; update_target = tgt; update_mispredict = 0;
    tick();
    update_valid = 0;
  endtask

  task automatic test_reset;
    reset_n = 0;
    fetch_pc = 32'h40;
    model_reset();
    #3;
    n_cmp++; if (pred_taken !== 1'b0) begin n_err++; $display("FAIL reset_taken got %b want 0", pred_taken); end
    n_cmp++; if (pred_target !== 32'h44) begin n_err++; $display("FAIL reset_target got %h want 44", pred_target); end
    n_cmp++; if (pc_sel !== 2'b00) begin n_err++; $display("FAIL reset_sel got %b want 00", pc_sel); end
    n_cmp++; if (pred_index !== 5'h10) begin n_err++; $display("FAIL reset_index got %h want 10", pred_index); end
    @(negedge clk) reset_n = 1;
    @(posedge clk); #1;
  endtask

  task automatic train_40;
    int k;
    k = 16 ^ ((m_ghr * 4 + 3) % 32);
    upd(32'h40, k, 1, 32'h100);
    upd(32'h40, k, 1, 32'h100);
  endtask

  task automatic test_train;
    int k;
    k = 16 ^ ((m_ghr * 4 + 3) % 32);
    train_40();
    fetch_pc = 32'h40;
    #1;
    n_cmp++; if (pred_taken !== 1'b1) begin n_err++; $display("FAIL train_taken got %b want 1", pred_taken); end
    n_cmp++; if (pred_target !== 32'h100) begin n_err++; $display("FAIL train_target got %h want 100", pred_target); end
    n_cmp++; if (pc_sel !== 2'b01) begin n_err++; $display("FAIL train_sel got %b want 01", pc_sel); end
    n_cmp++; if (pred_index !== 5'(k)) begin n_err++; $display("FAIL train_index got %h want %h", pred_index, k); end
  endtask

  task automatic test_saturation;
    logic [4:0] e_ix; logic e_tk; logic [31:0] e_tg;
    upd(32'h6C, 0, 1, 32'h200);
    upd(32'h14, 0, 1, 32'h280);
    upd(32'h18, 0, 1, 32'h300);
    for (int i = 0; i < 4; i++) upd(32'h6C, 5, 1, 32'h200);
    upd(32'h6C, 5, 0, 32'h200);
    fetch_pc = 32'h6C; #1;
    exp_out(fetch_pc, e_ix, e_tk, e_tg);
    n_cmp++; if (pred_index !== 5'd5) begin n_err++; $display("FAIL sat_up_index got %h want 05", pred_index); end
    n_cmp++; if (pred_taken !== 1'b1 || e_tk !== 1'b1) begin n_err++; $display("FAIL sat_up_taken got %b want 1", pred_taken); end
    n_cmp++; if (pred_target !== e_tg) begin n_err++; $display("FAIL sat_up_target got %h want %h", pred_target, e_tg); end
    for (int i = 0; i < 4; i++) upd(32'h14, 5, 0, 32'h0);
    fetch_pc = 32'h14; #1;
    exp_out(fetch_pc, e_ix, e_tk, e_tg);
    n_cmp++; if (pred_index !== 5'd5) begin n_err++; $display("FAIL sat_dn_index got %h want 05", pred_index); end
    n_cmp++; if (pred_taken !== 1'b0) begin n_err++; $display("FAIL sat_dn_taken got %b want 0", pred_taken); end
    upd(32'h14, 5, 0, 32'h0);
    fetch_pc = 32'h14; #1;
    n_cmp++; if (pred_taken !== 1'b0 || pred_target !== 32'h18) begin n_err++; $display("FAIL sat_floor got %b/%h want 0/18", pred_taken, pred_target); end
    upd(32'h30, 5, 1, 32'h400);
    fetch_pc = 32'h18; #1;
    n_cmp++; if (pred_taken !== 1'b0) begin n_err++; $display("FAIL sat_floor_plus1 got %b want 0", pred_taken); end
    upd(32'h34, 5, 1, 32'h400);
    fetch_pc = 32'h18; #1;
    exp_out(fetch_pc, e_ix, e_tk, e_tg);
    n_cmp++; if (pred_taken !== e_tk || pred_target !== e_tg) begin n_err++; $display("FAIL sat_floor_plus2 got %b/%h want %b/%h", pred_taken, pred_target, e_tk, e_tg); end
  endtask

  task automatic test_tag_miss;
    train_40();
    fetch_pc = 32'h40; #1;
    n_cmp++; if (pred_taken !== 1'b1) begin n_err++; $display("FAIL tag_hit got %b want 1", pred_taken); end
    fetch_pc = 32'hC0; #1;
    n_cmp++; if (pred_taken !== 1'b0 || pred_target !== 32'hC4 || pc_sel !== 2'b00) begin
      n_err++; $display("FAIL tag_miss got %b/%h/%b want 0/c4/00", pred_taken, pred_target, pc_sel); end
  endtask

  task automatic test_mispredict;
    logic [4:0] e_ix; logic e_tk; logic [31:0] e_tg;
    fetch_pc = 32'h40;
    update_valid = 1; update_mispredict = 1; update_taken = 0;
    update_pc = 32'h40; update_index = 5'(16 ^ m_ghr); update_target = 32'h0;
    #1;
    n_cmp++; if (pc_sel !== 2'b10) begin n_err++; $display("FAIL misp_sel got %b want 10", pc_sel); end
    n_cmp++; if (pred_taken !== 1'b1) begin n_err++; $display("FAIL misp_no_bypass got %b want 1", pred_taken); end
    update_valid = 0; #1;
    n_cmp++; if (pc_sel !== 2'b01) begin n_err++; $display("FAIL misp_ignored got %b want 01", pc_sel); end
    update_valid = 1;
    tick();
    update_valid = 0; update_mispredict = 0;
    #1;
    exp_out(fetch_pc, e_ix, e_tk, e_tg);
    n_cmp++; if (pred_taken !== e_tk || pred_index !== e_ix || pc_sel !== {1'b0, e_tk}) begin
      n_err++; $display("FAIL misp_after got %b/%h/%b want %b/%h", pred_taken, pred_index, pc_sel, e_tk, e_ix); end
  endtask

  task automatic test_random;
    logic [4:0] e_ix; logic e_tk; logic [31:0] e_tg; logic [1:0] e_sel;
    int bad;
    bad = 0;
    for (int i = 0; i < 400; i++) begin
      fetch_pc = (i % 50 == 0) ? 32'hFFFFFFFC : ($urandom_range(0, 1) << 7) | ($urandom_range(0, 31) << 2);
      update_valid = 1'($urandom_range(0, 1));
      update_pc = ($urandom_range(0, 1) << 7) | ($urandom_range(0, 31) << 2);
      update_index = 5'($urandom_range(0, 31));
      update_taken = 1'($urandom_range(0, 1));
      update_target = $urandom & 32'hFFFFFFFC;
      update_mispredict = ($urandom_range(0, 7) == 0);
      #1;
      exp_out(fetch_pc, e_ix, e_tk, e_tg);
      e_sel = (update_valid && update_mispredict) ? 2'b10 : e_tk ? 2'b01 : 2'b00;
      n_cmp++;
      if (pred_taken !== e_tk || pred_target !== e_tg || pred_index !== e_ix || pc_sel !== e_sel) begin
        n_err++;
        if (bad++ < 10) $display("FAIL rand[%0d] pc=%h got %b/%h/%h/%b want %b/%h/%h/%b", i, fetch_pc,
                                 pred_taken, pred_target, pred_index, pc_sel, e_tk, e_tg, e_ix, e_sel);
      end
      tick();
    end
    update_valid = 0; update_mispredict = 0;
  endtask

  task automatic test_async_reset;
    train_40();
    fetch_pc = 32'h40; #1;
    n_cmp++; if (pred_taken !== 1'b1) begin n_err++; $display("FAIL arst_pre got %b want 1", pred_taken); end
    update_valid = 1; update_taken = 1; update_mispredict = 1;
    update_pc = 32'h40; update_index = 5'd16; update_target = 32'h500;
    #2 reset_n = 0;
    model_reset();
    #1;
    n_cmp++; if (pred_taken !== 1'b0 || pc_sel !== 2'b00 || pred_target !== 32'h44 || pred_index !== 5'h10) begin
      n_err++; $display("FAIL arst_now got %b/%b/%h/%h want 0/00/44/10", pred_taken, pc_sel, pred_target, pred_index); end
    @(posedge clk); #1;
    update_valid = 0; update_mispredict = 0;
    @(negedge clk) reset_n = 1;
    @(posedge clk); #1;
    n_cmp++; if (pred_taken !== 1'b0 || pred_index !== 5'h10 || pred_target !== 32'h44) begin
      n_err++; $display("FAIL arst_after got %b/%h/%h want 0/10/44", pred_taken, pred_index, pred_target); end
  endtask

  initial begin
    test_reset();
    test_train();
    test_saturation();
    test_tag_miss();
    test_mispredict();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
